// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_reg
//  Description : Parametrised pipeline-stage register with a valid/ready
//                handshake and a 2-entry skid buffer (main = head, skid =
//                second). Supports stage freeze (hazard stall) and flush
//                (branch taken). A flush seen while frozen is held as pending
//                and applied on the first unfrozen cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
   parameter int unsigned DATA_W         = 64,
   parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              freeze_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occupancy_o,
   output logic              flush_pend_o
);

   // Occupancy state; the encoding doubles as the entry count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_q,  main_d;
   logic [DATA_W-1:0] skid_q,  skid_d;
   logic              flush_pend_q, flush_pend_d;

   logic              flush_eff;
   logic              in_fire;
   logic              out_fire;
   logic [DATA_W-1:0] flush_main_val;
   logic [DATA_W-1:0] flush_skid_val;

   // A deferred flush only takes effect once the freeze has lifted.
   assign flush_eff = (flush_i | flush_pend_q) & ~freeze_i;

   // in_ready is built from registered state and the freeze/flush inputs only,
   // so it never depends on out_ready. Gated by rst_n so nothing is offered
   // to upstream while reset is held.
   assign in_ready_o  = rst_n & (state_q != ST_TWO) & ~freeze_i
                        & ~flush_i & ~flush_pend_q;
   assign out_valid_o = (state_q != ST_EMPTY) & ~freeze_i & ~flush_eff;
   assign out_data_o  = main_q;
   assign occupancy_o = state_q;
   assign flush_pend_o = flush_pend_q;

   assign in_fire  = in_valid_i  & in_ready_o;
   assign out_fire = out_valid_o & out_ready_i;

   // Value the data registers take on a flush: zero, or unchanged.
   generate
      if (CLEAR_ON_FLUSH) begin : g_flush_clear
         assign flush_main_val = '0;
         assign flush_skid_val = '0;
      end else begin : g_flush_keep
         assign flush_main_val = main_q;
         assign flush_skid_val = skid_q;
      end
   endgenerate

   // Next-state logic: freeze > flush > normal handshake transfers.
   always_comb begin
      state_d      = state_q;
      main_d       = main_q;
      skid_d       = skid_q;
      flush_pend_d = flush_pend_q;

      if (freeze_i) begin
         // Everything holds; a flush arriving now is remembered.
         if (flush_i) begin
            flush_pend_d = 1'b1;
         end
      end else if (flush_eff) begin
         // Fresh or pending flush: one flush only, no transfers this cycle.
         state_d      = ST_EMPTY;
         main_d       = flush_main_val;
         skid_d       = flush_skid_val;
         flush_pend_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d = ST_ONE;
                  main_d  = in_data_i;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  // Head leaves and the new beat takes its place.
                  main_d = in_data_i;
               end else if (in_fire) begin
                  // Head is stalled; park the new beat behind it.
                  state_d = ST_TWO;
                  skid_d  = in_data_i;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so only a dequeue can occur; the skid
               // entry moves up to the head to keep FIFO order.
               if (out_fire) begin
                  state_d = ST_ONE;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // State and data registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_EMPTY;
         main_q       <= '0;
         skid_q       <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
         flush_pend_q <= flush_pend_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_skid_reg
//  Description : Scoreboard testbench for pipe_skid_reg. Stimulus pushes the
//                expected payload when a beat is accepted; a monitor pops and
//                compares whenever the block hands a beat downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

   localparam int unsigned DATA_W = 64;

   logic              clk;
   logic              rst_n;
   logic              freeze;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
   logic              flush_pend;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] exp_q[$];

   pipe_skid_reg #(
      .DATA_W        (DATA_W),
      .CLEAR_ON_FLUSH(1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .freeze_i    (freeze),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .occupancy_o (occupancy),
      .flush_pend_o(flush_pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every downstream transfer must match the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got %h, expected no output", out_data);
         end else begin
            logic [DATA_W-1:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               errors++;
               $display("FAIL out_data: got %h expected %h", out_data, e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Offer one beat and wait (bounded) until it is accepted.
   task automatic push(input logic [DATA_W-1:0] d);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(d);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: got not-accepted expected accepted data %h", d);
      end
   endtask

   // Wait (bounded) for the scoreboard to drain.
   task automatic wait_drain();
      for (int n = 0; n < 30 && exp_q.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; freeze = 1'b0; flush = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      // Reset state
      #12;
      chk("rst_out_valid",  out_valid,  0);
      chk("rst_out_data",   out_data,   0);
      chk("rst_occupancy",  occupancy,  0);
      chk("rst_flush_pend", flush_pend, 0);
      chk("rst_in_ready",   in_ready,   0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Streaming at full throughput
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         logic [DATA_W-1:0] v;
         v = 64'h1111 * (i + 1);
         in_valid = 1'b1;
         in_data  = v;
         @(negedge clk);
         chk("stream_in_ready", in_ready, 1);
         if (in_ready) exp_q.push_back(v);
         if (i > 0) chk("stream_occupancy", occupancy, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      wait_drain();
      @(negedge clk);
      chk("stream_empty_occ", occupancy, 0);

      // Backpressure fills the skid, then drains in order
      @(posedge clk); #1;
      out_ready = 1'b0;
      push(64'hA);
      push(64'hB);
      in_valid = 1'b1; in_data = 64'hC;
      @(negedge clk);
      chk("bp_occupancy", occupancy, 2);
      chk("bp_in_ready",  in_ready,  0);
      chk("bp_head",      out_data,  64'hA);
      @(posedge clk); #1;
      out_ready = 1'b1;
      push(64'hC);
      wait_drain();

      // Flush with two entries; concurrent in_valid must be refused
      out_ready = 1'b0;
      push(64'h21);
      push(64'h22);
      flush = 1'b1; in_valid = 1'b1; in_data = 64'h99;
      @(negedge clk);
      chk("flush_in_ready",  in_ready,  0);
      chk("flush_out_valid", out_valid, 0);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("flush_occupancy", occupancy, 0);
      chk("flush_out_valid2", out_valid, 0);
      chk("flush_out_data",  out_data,  0);
      chk("flush_in_ready2", in_ready,  1);

      // Flush during freeze is deferred, then applied once
      @(posedge clk); #1;
      push(64'h31);
      freeze = 1'b1; flush = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("frzfl_out_valid", out_valid, 0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("frzfl_pend",      flush_pend, 1);
      chk("frzfl_data_held", out_data,   64'h31);
      chk("frzfl_occ_held",  occupancy,  1);
      chk("frzfl_out_valid2", out_valid, 0);
      @(posedge clk); #1;
      freeze = 1'b0;
      @(negedge clk);
      chk("frzfl_rel_out_valid", out_valid, 0);
      chk("frzfl_rel_in_ready",  in_ready,  0);
      @(posedge clk); #1;
      exp_q.delete();
      @(negedge clk);
      chk("frzfl_occupancy", occupancy,  0);
      chk("frzfl_pend_clr",  flush_pend, 0);

      // Freeze with two entries and a willing sink
      @(posedge clk); #1;
      out_ready = 1'b0;
      push(64'h41);
      push(64'h42);
      freeze = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("frz_out_valid", out_valid, 0);
         chk("frz_occupancy", occupancy, 2);
         chk("frz_data",      out_data,  64'h41);
         @(posedge clk); #1;
      end
      freeze = 1'b0;
      wait_drain();

      // Asynchronous reset between clock edges, mid-stream
      out_ready = 1'b0;
      push(64'h51);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid,  0);
      chk("arst_out_data",  out_data,   0);
      chk("arst_occupancy", occupancy,  0);
      chk("arst_in_ready",  in_ready,   0);
      chk("arst_flush_pend", flush_pend, 0);
      exp_q.delete();
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      push(64'h77);
      chk("arst_after_valid", out_valid, 1);
      chk("arst_after_data",  out_data,  64'h77);
      wait_drain();

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised successor to the fetch-stage pipeline register. Any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) can use it.
- Adds a valid/ready handshake with a 2-entry skid buffer. Upstream sees backpressure through a registered path instead of a stall wire.
- Keeps stage-level freeze (hazard stall) and flush (branch taken).
- A flush that arrives during freeze is remembered and applied once the freeze lifts; it is not dropped.

Parameters:
DATA_W, 64, payload width (e.g. PC + instruction).
CLEAR_ON_FLUSH, 1, 1: flush zeroes the data registers; 0: flush clears only the valid state.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
freeze  input  1  stall: hold all state, no transfers
flush  input  1  discard all held entries
in_valid  input  1  upstream has data
in_ready  output  1  block accepts data this cycle
in_data  input  DATA_W  upstream payload
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts data
out_data  output  DATA_W  payload of the head entry (main register)
occupancy  output  2  entries held: 0, 1 or 2
flush_pend  output  1  a flush was seen during freeze and is not yet applied

Behaviour:
- Storage: main register (head) and skid register, each with a valid flag. State encoded as EMPTY (0 entries), ONE (main valid), TWO (main + skid valid). occupancy = 0/1/2.
- Effective flush: flush_eff = (flush | flush_pend) & ~freeze.
- Combinational outputs:
  - in_ready = (state != TWO) & ~freeze & ~flush & ~flush_pend
  - out_valid = (state != EMPTY) & ~freeze & ~flush_eff
  - out_data = main register at all times.
- Fire signals: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Transitions when ~freeze & ~flush_eff:
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE: in_fire & out_fire -> ONE, main <= in_data. in_fire only -> TWO, skid <= in_data. out_fire only -> EMPTY. Neither -> hold.
  - TWO: out_fire -> ONE, main <= skid. Otherwise hold. in_fire is impossible in TWO.
- Flush:
  - flush_eff -> state EMPTY next cycle.
  - If CLEAR_ON_FLUSH=1, main and skid data <= 0; otherwise data registers hold.
  - No transfer on either side in a flush_eff cycle.
  - flush_pend <= 0.
- Freeze:
  - All data, state and flags hold; no transfers.
  - flush during freeze sets flush_pend <= 1 (sticky). flush_pend stays 1 until the first non-frozen cycle, where it is applied and cleared.
- Simultaneous events:
  - freeze beats flush for the current cycle; the flush is deferred.
  - flush beats in_valid and out_ready.
  - Flush raised on the exact cycle freeze drops is applied that cycle (one flush, not two).
- Latency: 1 cycle in_fire -> out_valid when empty. Full throughput (1/cycle) in steady state with out_ready=1.
- Backpressure: in_ready depends only on registered state plus the freeze/flush inputs, never on out_ready.
- Data ordering: strict FIFO. The skid entry is never overtaken.
- Reset (rst_n low, asynchronous, any time including mid-transfer):
  - state EMPTY, main = skid = 0, flush_pend = 0.
  - Outputs: out_valid=0, out_data=0, occupancy=0, flush_pend=0, in_ready=0 while rst_n low.
  - First transfer is possible on the first clock edge after release.

Test Plan:
- Streaming: rst_n release, out_ready=1, push 0x1111 on consecutive cycles up to 0x5555 -> each appears on out_data one cycle after acceptance, in_ready stays 1, occupancy stays 1.
- Backpressure: out_ready=0, push 0xA, 0xB -> occupancy 2, in_ready=0, 0xC held upstream. Raise out_ready -> outputs 0xA, 0xB, 0xC in order, no loss or duplication.
- Flush with occupancy 2, CLEAR_ON_FLUSH=1 -> next cycle occupancy 0, out_valid=0, out_data=0. in_valid held high during the flush cycle -> not accepted.
- Flush during freeze: occupancy 1, freeze=1, pulse flush one cycle -> flush_pend=1, data held, out_valid=0. Drop freeze -> that cycle out_valid=0, next cycle occupancy 0 and flush_pend=0.
- Freeze with occupancy 2 and out_ready=1 for 3 cycles -> out_valid=0, no dequeue, data unchanged. Release -> normal drain.
- Async reset asserted mid-stream between clock edges -> outputs zero immediately. After release, push 0x77 -> out_data=0x77 one cycle later.
